// File: rtl/rtc_bus_arbiter_pkg.sv
// Shared types and constants for the RTC bus arbiter slice.
package rtc_arb_pkg;

  typedef enum logic [1:0] {
    INIT,
    WAIT_B,
    ARB
  } arb_state_e;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;

  // Wide enough for any supported channel count; users slice to N_CH.
  localparam int MAX_CH = 32;
  localparam logic [MAX_CH-1:0] IDLE_GRANT = '0;

endpackage

// File: rtl/rtc_bus_arbiter_if.sv
// Request/grant bundle between the mode state machines and the RTC protocol block.
interface rtc_bus_arbiter_if
  import rtc_arb_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
);

  logic [N_CH-1:0]    req;
  logic [N_CH*AW-1:0] addr_in;
  logic [N_CH*DW-1:0] data_in;
  logic               txn_boundary;
  logic [N_CH-1:0]    grant;
  logic [AW-1:0]      addr_out;
  logic [DW-1:0]      data_out;
  logic               rd_mode;
  logic               init_active;
  logic               preempt;

  modport master (
    output req, addr_in, data_in, txn_boundary,
    input  grant, addr_out, data_out, rd_mode, init_active, preempt
  );

  modport slave (
    input  req, addr_in, data_in, txn_boundary,
    output grant, addr_out, data_out, rd_mode, init_active, preempt
  );

endinterface

// File: rtl/rtc_bus_arbiter_pick.sv
// Combinational one-hot winner picker; fixed lowest-index by default,
// round-robin after last_idx (channel 0 still absolute) when ARB_RR_EN is defined.
module rtc_arb_pick #(
  parameter int N_CH = 4,
  parameter int IW   = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [N_CH-1:0] exclude,
  input  logic [IW-1:0]   last_idx,
  output logic [N_CH-1:0] winner
);

  logic [N_CH-1:0] masked;
  assign masked = req & ~exclude;

`ifdef ARB_RR_EN
  int unsigned cand;
  logic        found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    if (masked[0]) begin
      winner[0] = 1'b1;
    end else begin
      // Walk offsets 1..N_CH from last_idx so the last holder is tried last.
      for (int unsigned k = 1; k <= N_CH; k++) begin
        cand = (int'(last_idx) + k) % N_CH;
        for (int unsigned j = 1; j < N_CH; j++) begin
          if (!found && (j == cand) && masked[j]) begin
            winner[j] = 1'b1;
            found     = 1'b1;
          end
        end
      end
    end
  end
`else
  logic found;
  logic unused_last;
  assign unused_last = ^last_idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!found && masked[i]) begin
        winner[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Boundary-gated arbiter for the shared RTC parallel bus with init lockout,
// hold quota and preemption; ARB_RR_EN selects round-robin winner policy.
module rtc_bus_arbiter
  import rtc_arb_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int AW          = DEF_AW,
  parameter int DW          = DEF_DW,
  parameter int INIT_CYCLES = 1034,
  parameter int MAX_HOLD    = 0
) (
  input  logic             clk,
  input  logic             reset,
  rtc_bus_arbiter_if.slave bus
);

  localparam int              IW         = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int              CW         = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [CW-1:0]   INIT_LAST  = CW'(INIT_CYCLES - 1);
  localparam logic [N_CH-1:0] CH0_GRANT  = N_CH'(1);
  localparam logic [N_CH-1:0] NO_GRANT   = IDLE_GRANT[N_CH-1:0];
  localparam logic [31:0]     HOLD_LIMIT = 32'(MAX_HOLD);

  arb_state_e      state;
  logic [CW-1:0]   init_cnt;
  logic [31:0]     hold_cnt;
  logic [N_CH-1:0] grant_q;
  logic [N_CH-1:0] exclude;
  logic [N_CH-1:0] winner;
  logic [IW-1:0]   last_idx;
  logic [IW-1:0]   win_idx;
  logic            preempt_q;
  logic            init_active_q;
  logic            holder_req;
  logic            others_req;
  logic            keep;
  logic            revoke;

  always_comb begin
    holder_req = |(bus.req & grant_q);
    others_req = |(bus.req & ~grant_q);
    keep       = holder_req &&
                 ((MAX_HOLD == 0) || (hold_cnt < HOLD_LIMIT) || !others_req);
    revoke     = holder_req && !keep;
    exclude    = revoke ? grant_q : NO_GRANT;
  end

  rtc_arb_pick #(
    .N_CH (N_CH),
    .IW   (IW)
  ) u_pick (
    .req      (bus.req),
    .exclude  (exclude),
    .last_idx (last_idx),
    .winner   (winner)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (winner[i]) win_idx = IW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= INIT;
      grant_q       <= CH0_GRANT;
      init_cnt      <= '0;
      hold_cnt      <= '0;
      last_idx      <= '0;
      preempt_q     <= 1'b0;
      init_active_q <= 1'b1;
    end else begin
      preempt_q <= 1'b0;
      unique case (state)
        INIT: begin
          // A boundary coinciding with expiry is deliberately not consumed here.
          if (init_cnt == INIT_LAST) begin
            state         <= WAIT_B;
            init_active_q <= 1'b0;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        WAIT_B, ARB: begin
          if (bus.txn_boundary) begin
            state <= ARB;
            if (keep) begin
              if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
            end else begin
              grant_q   <= winner;
              hold_cnt  <= '0;
              preempt_q <= revoke;
              if (|winner) last_idx <= win_idx;
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  always_comb begin
    bus.addr_out = '0;
    bus.data_out = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      bus.addr_out = bus.addr_out | (bus.addr_in[i*AW +: AW] & {AW{grant_q[i]}});
      bus.data_out = bus.data_out | (bus.data_in[i*DW +: DW] & {DW{grant_q[i]}});
    end
  end

  assign bus.grant       = grant_q;
  assign bus.rd_mode     = (grant_q == NO_GRANT);
  assign bus.init_active = init_active_q;
  assign bus.preempt     = preempt_q;

endmodule
